// File: rtl/rs_issue_scheduler_if.sv
// Scheduler <-> reservation-station bus: entry requests/classes in; clear vector and issue slots out.
// Stats counters (RS_SCHED_STATS_EN) appear only when that macro is defined.
`timescale 1ns/1ps
interface rs_issue_scheduler_if #(
   parameter int RS_LEN = 8,
   parameter int IDX_W  = $clog2(RS_LEN)
);
   logic                  squash;
   logic [RS_LEN-1:0]     rs_entry_ready;
   logic [2*RS_LEN-1:0]   rs_entry_fu_type;
   logic                  mem_ready;
   logic [RS_LEN-1:0]     rs_entry_clear_out;
   logic                  alu_issue_valid;
   logic [IDX_W-1:0]      alu_issue_idx;
   logic                  mult_issue_valid;
   logic [IDX_W-1:0]      mult_issue_idx;
   logic                  mem_issue_valid;
   logic [IDX_W-1:0]      mem_issue_idx;
   logic                  mult_busy;
`ifdef RS_SCHED_STATS_EN
   logic [31:0]           issue_count;
   logic [31:0]           stall_count;

   modport master (
      output squash, rs_entry_ready, rs_entry_fu_type, mem_ready,
      input  rs_entry_clear_out, alu_issue_valid, alu_issue_idx, mult_issue_valid,
             mult_issue_idx, mem_issue_valid, mem_issue_idx, mult_busy,
             issue_count, stall_count
   );
   modport slave (
      input  squash, rs_entry_ready, rs_entry_fu_type, mem_ready,
      output rs_entry_clear_out, alu_issue_valid, alu_issue_idx, mult_issue_valid,
             mult_issue_idx, mem_issue_valid, mem_issue_idx, mult_busy,
             issue_count, stall_count
   );
`else
   modport master (
      output squash, rs_entry_ready, rs_entry_fu_type, mem_ready,
      input  rs_entry_clear_out, alu_issue_valid, alu_issue_idx, mult_issue_valid,
             mult_issue_idx, mem_issue_valid, mem_issue_idx, mult_busy
   );
   modport slave (
      input  squash, rs_entry_ready, rs_entry_fu_type, mem_ready,
      output rs_entry_clear_out, alu_issue_valid, alu_issue_idx, mult_issue_valid,
             mult_issue_idx, mem_issue_valid, mem_issue_idx, mult_busy
   );
`endif
endinterface

// File: rtl/rs_issue_scheduler.sv
// RS select/issue: round-robin pick per FU class (ALU/MULT/MEM); clear same cycle, issue regs 1 cycle later.
// Backpressure: MULT held while multiplier busy, ALU held on CDB collision slot, MEM held on !mem_ready; RS_SCHED_STATS_EN adds counters.
`timescale 1ns/1ps
module rs_issue_scheduler #(
   parameter int RS_LEN   = 8,
   parameter int IDX_W    = $clog2(RS_LEN),
   parameter int MULT_LAT = 4
) (
   input logic                i_clk,
   input logic                i_rst_n,
   rs_issue_scheduler_if.slave rs_if
);
   localparam int CNT_W = $clog2(MULT_LAT + 1);

   logic [RS_LEN-1:0] w_req_alu, w_req_mult, w_req_mem, w_clear;
   logic [IDX_W:0]    w_alu_pick, w_mult_pick, w_mem_pick;
   logic              w_alu_gnt, w_mult_gnt, w_mem_gnt;
   logic [IDX_W-1:0]  r_rr_alu, r_rr_mult, r_rr_mem;
   logic [IDX_W-1:0]  r_alu_idx, r_mult_idx, r_mem_idx;
   logic              r_alu_vld, r_mult_vld, r_mem_vld;
   logic [CNT_W-1:0]  r_mult_cnt;

   // Returns {found, idx}; scanning downward lets the entry nearest the pointer win.
   function automatic logic [IDX_W:0] rr_pick(input logic [RS_LEN-1:0] req,
                                              input logic [IDX_W-1:0]  ptr);
      logic [IDX_W-1:0] j;
      rr_pick = '0;
      for (int k = RS_LEN - 1; k >= 0; k--) begin
         j = ptr + IDX_W'(k);
         if (req[j]) rr_pick = {1'b1, j};
      end
   endfunction

   always_comb begin
      w_req_alu  = '0;
      w_req_mult = '0;
      w_req_mem  = '0;
      for (int i = 0; i < RS_LEN; i++) begin
         w_req_alu[i]  = rs_if.rs_entry_ready[i] &&
                         (rs_if.rs_entry_fu_type[2*i +: 2] == 2'd0 ||
                          rs_if.rs_entry_fu_type[2*i +: 2] == 2'd3);
         w_req_mult[i] = rs_if.rs_entry_ready[i] && (rs_if.rs_entry_fu_type[2*i +: 2] == 2'd1);
         w_req_mem[i]  = rs_if.rs_entry_ready[i] && (rs_if.rs_entry_fu_type[2*i +: 2] == 2'd2);
      end
   end

   assign w_alu_pick  = rr_pick(w_req_alu,  r_rr_alu);
   assign w_mult_pick = rr_pick(w_req_mult, r_rr_mult);
   assign w_mem_pick  = rr_pick(w_req_mem,  r_rr_mem);

   // An ALU op issued while mult_cnt==2 would hit the CDB in the same cycle as the multiply result.
   assign w_alu_gnt  = w_alu_pick[IDX_W]  && !rs_if.squash && (r_mult_cnt != CNT_W'(2));
   assign w_mult_gnt = w_mult_pick[IDX_W] && !rs_if.squash && (r_mult_cnt == '0);
   assign w_mem_gnt  = w_mem_pick[IDX_W]  && !rs_if.squash && rs_if.mem_ready;

   always_comb begin
      w_clear = '0;
      if (w_alu_gnt)  w_clear[w_alu_pick[IDX_W-1:0]]  = 1'b1;
      if (w_mult_gnt) w_clear[w_mult_pick[IDX_W-1:0]] = 1'b1;
      if (w_mem_gnt)  w_clear[w_mem_pick[IDX_W-1:0]]  = 1'b1;
   end

   assign rs_if.rs_entry_clear_out = i_rst_n ? w_clear : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_alu_vld  <= 1'b0;
         r_mult_vld <= 1'b0;
         r_mem_vld  <= 1'b0;
         r_alu_idx  <= '0;
         r_mult_idx <= '0;
         r_mem_idx  <= '0;
         r_rr_alu   <= '0;
         r_rr_mult  <= '0;
         r_rr_mem   <= '0;
         r_mult_cnt <= '0;
      end else if (rs_if.squash) begin
         r_alu_vld  <= 1'b0;
         r_mult_vld <= 1'b0;
         r_mem_vld  <= 1'b0;
         r_mult_cnt <= '0;
      end else begin
         r_alu_vld  <= w_alu_gnt;
         r_mult_vld <= w_mult_gnt;
         r_mem_vld  <= w_mem_gnt;
         if (w_alu_gnt) begin
            r_alu_idx <= w_alu_pick[IDX_W-1:0];
            r_rr_alu  <= w_alu_pick[IDX_W-1:0] + IDX_W'(1);
         end
         if (w_mult_gnt) begin
            r_mult_idx <= w_mult_pick[IDX_W-1:0];
            r_rr_mult  <= w_mult_pick[IDX_W-1:0] + IDX_W'(1);
         end
         if (w_mem_gnt) begin
            r_mem_idx <= w_mem_pick[IDX_W-1:0];
            r_rr_mem  <= w_mem_pick[IDX_W-1:0] + IDX_W'(1);
         end
         if (w_mult_gnt)
            r_mult_cnt <= CNT_W'(MULT_LAT);
         else if (r_mult_cnt != '0)
            r_mult_cnt <= r_mult_cnt - CNT_W'(1);
      end
   end

   assign rs_if.alu_issue_valid  = r_alu_vld;
   assign rs_if.alu_issue_idx    = r_alu_idx;
   assign rs_if.mult_issue_valid = r_mult_vld;
   assign rs_if.mult_issue_idx   = r_mult_idx;
   assign rs_if.mem_issue_valid  = r_mem_vld;
   assign rs_if.mem_issue_idx    = r_mem_idx;
   assign rs_if.mult_busy        = (r_mult_cnt != '0);

`ifdef RS_SCHED_STATS_EN
   logic [31:0] r_issue_count, r_stall_count;
   logic [31:0] w_n_gnt;

   assign w_n_gnt = 32'(w_alu_gnt) + 32'(w_mult_gnt) + 32'(w_mem_gnt);

   // Counters run through squash: a squashed cycle with ready entries counts as a stall.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_issue_count <= '0;
         r_stall_count <= '0;
      end else begin
         r_issue_count <= r_issue_count + w_n_gnt;
         if ((|rs_if.rs_entry_ready) && (w_n_gnt == 32'd0))
            r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign rs_if.issue_count = r_issue_count;
   assign rs_if.stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed vectors with literal expectations plus a per-cycle reference model.
`timescale 1ns/1ps
module tb_rs_issue_scheduler;
   localparam int RS_LEN   = 8;
   localparam int IDX_W    = 3;
   localparam int MULT_LAT = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   rs_issue_scheduler_if #(.RS_LEN(RS_LEN), .IDX_W(IDX_W)) bus ();

   rs_issue_scheduler #(.RS_LEN(RS_LEN), .IDX_W(IDX_W), .MULT_LAT(MULT_LAT)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .rs_if   (bus)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;
   logic [1:0] ty [RS_LEN];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   // Reference model: class 0=ALU (types 0,3), 1=MULT, 2=MEM.
   // Multiplier occupancy is tracked as the last cycle number the multiplier is busy.
   int   m_rr [3];
   logic m_v  [3];
   int   m_i  [3];
   int   m_done = -100;
   int   m_cyc  = 0;

   function automatic int cls_of(input logic [1:0] t);
      if (t == 2'd1) return 1;
      if (t == 2'd2) return 2;
      return 0;
   endfunction

   always @(negedge clk) begin : model
      logic [7:0] e_clr;
      bit         g  [3];
      int         gi [3];
      bit         ok [3];
      int         j;
      if (!rst_n) begin
         for (int c = 0; c < 3; c++) begin
            m_rr[c] = 0; m_v[c] = 1'b0; m_i[c] = 0;
         end
         m_done = -100;
         chk("rst_clear", 32'(bus.rs_entry_clear_out), 32'h0);
         chk("rst_alu_vld", 32'(bus.alu_issue_valid), 32'h0);
         chk("rst_mult_vld", 32'(bus.mult_issue_valid), 32'h0);
         chk("rst_mem_vld", 32'(bus.mem_issue_valid), 32'h0);
         chk("rst_busy", 32'(bus.mult_busy), 32'h0);
      end else begin
         chk("m_alu_vld",  32'(bus.alu_issue_valid),  32'(m_v[0]));
         chk("m_alu_idx",  32'(bus.alu_issue_idx),    32'(m_i[0]));
         chk("m_mult_vld", 32'(bus.mult_issue_valid), 32'(m_v[1]));
         chk("m_mult_idx", 32'(bus.mult_issue_idx),   32'(m_i[1]));
         chk("m_mem_vld",  32'(bus.mem_issue_valid),  32'(m_v[2]));
         chk("m_mem_idx",  32'(bus.mem_issue_idx),    32'(m_i[2]));
         chk("m_busy",     32'(bus.mult_busy),        32'(m_cyc <= m_done));
         // ALU result lands at cyc+2, multiply result at m_done+1.
         ok[0] = (m_cyc + 2 != m_done + 1);
         ok[1] = (m_cyc > m_done);
         ok[2] = bus.mem_ready;
         e_clr = '0;
         for (int c = 0; c < 3; c++) begin
            g[c] = 0; gi[c] = 0;
            if (!bus.squash && ok[c]) begin
               for (int k = 0; k < RS_LEN; k++) begin
                  j = (m_rr[c] + k) % RS_LEN;
                  if (!g[c] && bus.rs_entry_ready[j] && cls_of(bus.rs_entry_fu_type[2*j +: 2]) == c) begin
                     g[c] = 1; gi[c] = j; e_clr[j] = 1'b1;
                  end
               end
            end
         end
         chk("m_clear", 32'(bus.rs_entry_clear_out), 32'(e_clr));
         if (bus.squash) begin
            for (int c = 0; c < 3; c++) m_v[c] = 1'b0;
            m_done = -100;
         end else begin
            for (int c = 0; c < 3; c++) begin
               m_v[c] = g[c];
               if (g[c]) begin
                  m_i[c]  = gi[c];
                  m_rr[c] = (gi[c] + 1) % RS_LEN;
               end
            end
            if (g[1]) m_done = m_cyc + MULT_LAT;
         end
      end
      m_cyc++;
   end

   // Drives one cycle of inputs at posedge+1 and returns at posedge+3.
   task automatic drive(input logic [7:0] rdy, input logic mr, input logic sq);
      @(posedge clk);
      #1;
      bus.rs_entry_ready = rdy;
      bus.mem_ready      = mr;
      bus.squash         = sq;
      for (int i = 0; i < RS_LEN; i++) bus.rs_entry_fu_type[2*i +: 2] = ty[i];
      #2;
   endtask

   initial begin
      for (int i = 0; i < RS_LEN; i++) ty[i] = 2'd0;
      bus.squash = 1'b0; bus.rs_entry_ready = '0; bus.mem_ready = 1'b0; bus.rs_entry_fu_type = '0;
      #1 rst_n = 1'b0;

      // Reset: no clears even with every entry ready.
      drive(8'hFF, 1'b1, 1'b0);
      chk("reset_clear", 32'(bus.rs_entry_clear_out), 32'h00);
      chk("reset_alu_vld", 32'(bus.alu_issue_valid), 32'h0);
      chk("reset_busy", 32'(bus.mult_busy), 32'h0);
      drive(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Single ALU request.
      drive(8'h01, 1'b0, 1'b0);
      chk("t1_clear", 32'(bus.rs_entry_clear_out), 32'h01);
      drive(8'h00, 1'b0, 1'b0);
      chk("t1_alu_vld", 32'(bus.alu_issue_valid), 32'h1);
      chk("t1_alu_idx", 32'(bus.alu_issue_idx), 32'h0);

      // Wrap-around: move pointer to 7, then requests at 0 and 7.
      drive(8'h40, 1'b0, 1'b0);
      chk("t2_clear6", 32'(bus.rs_entry_clear_out), 32'h40);
      drive(8'h81, 1'b0, 1'b0);
      chk("t2_clear7", 32'(bus.rs_entry_clear_out), 32'h80);
      drive(8'h01, 1'b0, 1'b0);
      chk("t2_clear0", 32'(bus.rs_entry_clear_out), 32'h01);
      chk("t2_alu_idx7", 32'(bus.alu_issue_idx), 32'h7);
      drive(8'h00, 1'b0, 1'b0);
      chk("t2_alu_idx0", 32'(bus.alu_issue_idx), 32'h0);

      // Multiplier occupancy.
      ty[2] = 2'd1; ty[5] = 2'd1;
      drive(8'h04, 1'b0, 1'b0);
      chk("t3_clear2", 32'(bus.rs_entry_clear_out), 32'h04);
      drive(8'h20, 1'b0, 1'b0);
      chk("t3_hold5", 32'(bus.rs_entry_clear_out), 32'h00);
      chk("t3_mult_vld", 32'(bus.mult_issue_valid), 32'h1);
      chk("t3_mult_idx", 32'(bus.mult_issue_idx), 32'h2);
      for (int n = 0; n < 3; n++) begin
         drive(8'h20, 1'b0, 1'b0);
         chk("t3_busy", 32'(bus.mult_busy), 32'h1);
         chk("t3_hold", 32'(bus.rs_entry_clear_out), 32'h00);
      end
      drive(8'h20, 1'b0, 1'b0);
      chk("t3_free_busy", 32'(bus.mult_busy), 32'h0);
      chk("t3_clear5", 32'(bus.rs_entry_clear_out), 32'h20);

      // CDB collision slot blocks ALU when mult_cnt==2.
      drive(8'h00, 1'b0, 1'b0);
      chk("t4_mult_idx", 32'(bus.mult_issue_idx), 32'h5);
      drive(8'h00, 1'b0, 1'b0);
      drive(8'h08, 1'b0, 1'b0);
      chk("t4_alu_blocked", 32'(bus.rs_entry_clear_out), 32'h00);
      drive(8'h08, 1'b0, 1'b0);
      chk("t4_alu_granted", 32'(bus.rs_entry_clear_out), 32'h08);

      // All three classes.
      ty[4] = 2'd1; ty[6] = 2'd2;
      drive(8'h52, 1'b0, 1'b0);
      chk("t5_clear_nomem", 32'(bus.rs_entry_clear_out), 32'h12);
      drive(8'h40, 1'b0, 1'b0);
      chk("t5_mem_stall", 32'(bus.rs_entry_clear_out), 32'h00);
      for (int n = 0; n < 3; n++) drive(8'h00, 1'b0, 1'b0);
      drive(8'h52, 1'b1, 1'b0);
      chk("t5_clear_all", 32'(bus.rs_entry_clear_out), 32'h52);
      drive(8'h00, 1'b1, 1'b0);
      chk("t5_alu_idx", 32'(bus.alu_issue_idx), 32'h1);
      chk("t5_mult_idx", 32'(bus.mult_issue_idx), 32'h4);
      chk("t5_mem_vld", 32'(bus.mem_issue_valid), 32'h1);
      chk("t5_mem_idx", 32'(bus.mem_issue_idx), 32'h6);

      // Squash during a multiply with pending grants.
      drive(8'h42, 1'b1, 1'b1);
      chk("t6_sq_clear", 32'(bus.rs_entry_clear_out), 32'h00);
      drive(8'h1A, 1'b1, 1'b0);
      chk("t6_sq_alu_vld", 32'(bus.alu_issue_valid), 32'h0);
      chk("t6_sq_mem_vld", 32'(bus.mem_issue_valid), 32'h0);
      chk("t6_sq_busy", 32'(bus.mult_busy), 32'h0);
      chk("t6_after_clear", 32'(bus.rs_entry_clear_out), 32'h18);
      drive(8'h00, 1'b0, 1'b0);
      chk("t6_pre_alu_idx", 32'(bus.alu_issue_idx), 32'h3);
      chk("t6_pre_busy", 32'(bus.mult_busy), 32'h1);

      // Async reset in the middle of a multiply.
      rst_n = 1'b0;
      bus.rs_entry_ready = 8'h81;
      #1;
      chk("t6_rst_alu_vld", 32'(bus.alu_issue_valid), 32'h0);
      chk("t6_rst_mult_vld", 32'(bus.mult_issue_valid), 32'h0);
      chk("t6_rst_mult_idx", 32'(bus.mult_issue_idx), 32'h0);
      chk("t6_rst_busy", 32'(bus.mult_busy), 32'h0);
      chk("t6_rst_clear", 32'(bus.rs_entry_clear_out), 32'h00);
      drive(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(8'h81, 1'b0, 1'b0);
      chk("t6_rr_reset", 32'(bus.rs_entry_clear_out), 32'h01);

      // Mixed traffic, checked by the model.
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < RS_LEN; i++) ty[i] = 2'($urandom_range(0, 3));
         drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
      drive(8'h00, 1'b0, 1'b0);
      @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
